// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory responder: fixed-latency RV32I loads/stores with byte lanes,
// sign/zero extension and misalignment/illegal-size faults, stalling the pipeline while busy.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic [31:0] read_data_M,
  output logic        stall_M,
  output logic        access_fault_M
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg;
  logic [3:0]  count_reg;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_word_reg;

  logic          req;
  logic          fault;
  logic          is_store;
  logic [AW-1:0] word_idx;
  logic [3:0]    byte_en;
  logic [31:0]   store_lanes;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [31:0]   load_value;
  logic          unused_addr_bits;

  assign req      = mem_read_M | mem_write_M;
  assign is_store = mem_write_M;
  assign word_idx = addr_M[2 +: AW];
  assign unused_addr_bits = ^addr_M[31:AW+2];

  always_comb begin
    fault = 1'b0;
    if (req) begin
      case (funct3_M)
        3'b011, 3'b110, 3'b111: fault = 1'b1;
        3'b001, 3'b101:         fault = addr_M[0];
        3'b010:                 fault = |addr_M[1:0];
        default:                fault = 1'b0;
      endcase
    end
  end

  assign access_fault_M = fault;
  assign stall_M = ((state_reg == IDLE) && req && !fault) || (state_reg == BUSY);

  // Store lanes: data is replicated across the word, byte enables pick the target lanes.
  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = wdata_M;
    case (funct3_M[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << addr_M[1:0];
        store_lanes = {4{wdata_M[7:0]}};
      end
      2'b01: begin
        byte_en     = addr_M[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{wdata_M[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    load_byte  = mem_word_reg[8*addr_M[1:0] +: 8];
    load_half  = addr_M[1] ? mem_word_reg[31:16] : mem_word_reg[15:0];
    load_value = 32'd0;
    case (funct3_M)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b010:  load_value = mem_word_reg;
      3'b100:  load_value = {24'd0, load_byte};
      3'b101:  load_value = {16'd0, load_half};
      default: load_value = 32'd0;
    endcase
  end

  // Only the DONE cycle of a load drives data so MEM_WB bubbles carry zero.
  assign read_data_M = ((state_reg == DONE) && mem_read_M && !is_store && !fault)
                       ? load_value : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req && !fault) begin
            count_reg <= 4'(LATENCY - 1);
            state_reg <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          count_reg <= count_reg - 4'd1;
          if (count_reg == 4'd1) state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Array with registered read; the read word settles well before DONE since inputs are held.
  always_ff @(posedge clk) begin
    mem_word_reg <= mem[word_idx];
    if (!reset && (state_reg == DONE) && is_store && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl with LATENCY=2, DEPTH_WORDS=1024.
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_M;
  logic        mem_write_M;
  logic [2:0]  funct3_M;
  logic [31:0] addr_M;
  logic [31:0] wdata_M;
  logic [31:0] read_data_M;
  logic        stall_M;
  logic        access_fault_M;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_read_M(mem_read_M), .mem_write_M(mem_write_M),
    .funct3_M(funct3_M), .addr_M(addr_M), .wdata_M(wdata_M),
    .read_data_M(read_data_M), .stall_M(stall_M), .access_fault_M(access_fault_M)
  );

  // Drives one request until its DONE cycle (or a fault), then returns the bus to idle.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rdata,
                        output logic fault, output logic [31:0] bubble_or);
    mem_read_M = rd; mem_write_M = wr; funct3_M = f3; addr_M = a; wdata_M = wd;
    stalls = 0; rdata = 32'd0; fault = 1'b0; bubble_or = 32'd0;
    @(negedge clk);
    if (access_fault_M) begin
      fault = 1'b1;
      stalls = stall_M ? 1 : 0;
      rdata = read_data_M;
    end else begin
      while (stall_M && stalls < 40) begin
        bubble_or |= read_data_M;
        stalls++;
        @(negedge clk);
      end
      rdata = read_data_M;
    end
    @(posedge clk); #1;
    mem_read_M = 1'b0; mem_write_M = 1'b0; funct3_M = 3'b000; addr_M = 32'd0; wdata_M = 32'd0;
    $display("[TB] rd=%0b wr=%0b f3=%03b addr=%08h wd=%08h -> stalls=%0d rdata=%08h fault=%0b",
             rd, wr, f3, a, wd, stalls, rdata, fault);
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read_M = 1'b0; mem_write_M = 1'b0; funct3_M = 3'b000;
    addr_M = 32'd0; wdata_M = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (stall_M !== 1'b0 || access_fault_M !== 1'b0 || read_data_M !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: stall=%b fault=%b rdata=%08h, want 0 0 00000000",
               stall_M, access_fault_M, read_data_M);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int s; logic [31:0] r, b; logic f;
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, s, r, f, b);
    tests_run++;
    if (s !== LAT || f !== 1'b0 || r !== 32'd0) begin
      tests_failed++;
      $display("FAIL sw_timing: stalls=%0d fault=%b rdata=%08h, want %0d 0 00000000", s, f, r, LAT);
    end
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, s, r, f, b);
    tests_run++;
    if (s !== LAT || r !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL lw_data: stalls=%0d rdata=%08h, want %0d deadbeef", s, r, LAT);
    end
    tests_run++;
    if (b !== 32'd0) begin
      tests_failed++;
      $display("FAIL bubble_zero: read_data during stall=%08h, want 00000000", b);
    end
  endtask

  task automatic test_bytes();
    int s; logic [31:0] r, b; logic f;
    access(1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, s, r, f, b);
    access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'hFFFFFF80) begin
      tests_failed++;
      $display("FAIL lb_sext: got %08h want ffffff80", r);
    end
    access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'h00000080) begin
      tests_failed++;
      $display("FAIL lbu_zext: got %08h want 00000080", r);
    end
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'h80ADBEEF) begin
      tests_failed++;
      $display("FAIL sb_merge: got %08h want 80adbeef", r);
    end
  endtask

  task automatic test_faults();
    int s; logic [31:0] r, b; logic f;
    access(1'b1, 1'b0, 3'b001, 32'h11, 32'h0, s, r, f, b);
    tests_run++;
    if (f !== 1'b1 || s !== 0 || r !== 32'd0) begin
      tests_failed++;
      $display("FAIL lh_misaligned: fault=%b stall=%0d rdata=%08h, want 1 0 00000000", f, s, r);
    end
    access(1'b0, 1'b1, 3'b011, 32'h10, 32'h11111111, s, r, f, b);
    tests_run++;
    if (f !== 1'b1 || s !== 0) begin
      tests_failed++;
      $display("FAIL f3_011_store: fault=%b stall=%0d, want 1 0", f, s);
    end
    access(1'b0, 1'b1, 3'b010, 32'h12, 32'h22222222, s, r, f, b);
    tests_run++;
    if (f !== 1'b1) begin
      tests_failed++;
      $display("FAIL sw_misaligned: fault=%b want 1", f);
    end
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'h80ADBEEF || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_no_write: got %08h fault=%b want 80adbeef 0", r, f);
    end
  endtask

  task automatic test_half();
    int s; logic [31:0] r, b; logic f;
    access(1'b0, 1'b1, 3'b001, 32'h12, 32'h1234ABCD, s, r, f, b);
    access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'hFFFFABCD) begin
      tests_failed++;
      $display("FAIL lh_sext: got %08h want ffffabcd", r);
    end
    access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'h0000ABCD) begin
      tests_failed++;
      $display("FAIL lhu_zext: got %08h want 0000abcd", r);
    end
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'hABCDBEEF) begin
      tests_failed++;
      $display("FAIL sh_merge: got %08h want abcdbeef", r);
    end
  endtask

  task automatic test_reset_mid_op();
    int s; logic [31:0] r, b; logic f;
    access(1'b0, 1'b1, 3'b010, 32'h0, 32'hA5A5A5A5, s, r, f, b);
    mem_write_M = 1'b1; funct3_M = 3'b010; addr_M = 32'h0; wdata_M = 32'h12345678;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_write_M = 1'b0; wdata_M = 32'd0;
    @(negedge clk);
    tests_run++;
    if (stall_M !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort_stall: stall=%b want 0", stall_M);
    end
    @(posedge clk); #1;
    access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'hA5A5A5A5) begin
      tests_failed++;
      $display("FAIL reset_no_write: got %08h want a5a5a5a5", r);
    end
  endtask

  task automatic test_wrap();
    int s; logic [31:0] r, b; logic f;
    access(1'b0, 1'b1, 3'b010, DEPTH * 4 + 8, 32'hCAFEF00D, s, r, f, b);
    access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL wrap_around: got %08h want cafef00d", r);
    end
  endtask

  task automatic test_back_to_back();
    int s; logic [31:0] r, b; logic f;
    access(1'b1, 1'b1, 3'b010, 32'h20, 32'h11223344, s, r, f, b);
    tests_run++;
    if (r !== 32'd0 || s !== LAT) begin
      tests_failed++;
      $display("FAIL rw_both_rdata: got %08h stalls=%0d want 00000000 %0d", r, s, LAT);
    end
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, s, r, f, b);
    tests_run++;
    if (r !== 32'h11223344 || s !== LAT) begin
      tests_failed++;
      $display("FAIL rw_both_store: got %08h stalls=%0d want 11223344 %0d", r, s, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_bytes();
    test_faults();
    test_half();
    test_reset_mid_op();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
